// File: rtl/hex_display_pkg.sv
// Shared constants for the eight-digit multiplexed hex display: digit count,
// segment width and active-low {g,f,e,d,c,b,a} patterns for each hex nibble.
package hex_display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  // Hex glyph lookup.
  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0:    seg_o = SEG_0;
      4'h1:    seg_o = SEG_1;
      4'h2:    seg_o = SEG_2;
      4'h3:    seg_o = SEG_3;
      4'h4:    seg_o = SEG_4;
      4'h5:    seg_o = SEG_5;
      4'h6:    seg_o = SEG_6;
      4'h7:    seg_o = SEG_7;
      4'h8:    seg_o = SEG_8;
      4'h9:    seg_o = SEG_9;
      4'hA:    seg_o = SEG_A;
      4'hB:    seg_o = SEG_B;
      4'hC:    seg_o = SEG_C;
      4'hD:    seg_o = SEG_D;
      4'hE:    seg_o = SEG_E;
      4'hF:    seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Eight-digit multiplexed hex display with a double-buffered value that only swaps at frame ends.
// Optional macro HEX_BLANK_LEADING_ZEROS_EN blanks leading-zero digits (digit 0 always shown).
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [31:0]      data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic [7:0]       an_o,
  output logic [SEG_W-1:0] seg_o,
  output logic             dp_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      disp_q, disp_d;
  logic [31:0]      pend_q, pend_d;
  logic             pfull_q, pfull_d;

  logic             ready_s;
  logic             xfer_s;
  logic             tick_s;
  logic             frame_s;
  logic             scan_s;
  logic             blank_lz_s;
  logic [3:0]       nibble_s;
  logic [SEG_W-1:0] dec_seg_s;

  assign ready_s = ~pfull_q & ~rst_i;
  assign xfer_s  = data_valid_i & ready_s;
  assign tick_s  = en_i & (cnt_q == CNT_MAX);
  assign frame_s = tick_s & (idx_q == 3'd7);

  // Scan timing and buffer management; while scanning, display only changes at a frame boundary.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    pfull_d = pfull_q;
    if (en_i) begin
      if (tick_s) begin
        cnt_d = '0;
        idx_d = idx_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (xfer_s) begin
        pend_d  = data_i;
        pfull_d = 1'b1;
      end else if (frame_s && pfull_q) begin
        disp_d  = pend_q;
        pfull_d = 1'b0;
      end else begin
        pfull_d = pfull_q;
      end
    end else begin
      if (pfull_q) begin
        disp_d  = pend_q;
        pfull_d = 1'b0;
      end else if (xfer_s) begin
        disp_d = data_i;
      end else begin
        disp_d = disp_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      disp_q  <= 32'd0;
      pend_q  <= 32'd0;
      pfull_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pfull_q <= pfull_d;
    end
  end

  assign scan_s   = en_i & ~rst_i;
  assign nibble_s = disp_q[{idx_q, 2'b00} +: 4];

`ifdef HEX_BLANK_LEADING_ZEROS_EN
  assign blank_lz_s = (idx_q != 3'd0) && ((disp_q >> {idx_q, 2'b00}) == 32'd0);
`else
  assign blank_lz_s = 1'b0;
`endif

  hex_seg_decoder u_dec (
    .nibble_i (nibble_s),
    .seg_o    (dec_seg_s)
  );

  assign data_ready_o = ready_s;
  assign an_o         = scan_s ? ~(8'b1 << idx_q) : 8'hFF;
  assign seg_o        = (!scan_s || blank_lz_s) ? SEG_BLANK : dec_seg_s;
  assign dp_o         = 1'b1;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl with TICK_DIV=4: a per-cycle reference
// model plus directed scenarios with hand-computed segment/anode values.
module tb_hex_display_ctrl;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  always #5 clk = ~clk;

  hex_display_ctrl #(.TICK_DIV(TD)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .data_i       (data),
    .data_valid_i (valid),
    .data_ready_o (ready),
    .an_o         (an),
    .seg_o        (seg),
    .dp_o         (dp)
  );

  int checks = 0;
  int errors = 0;

  // Standard active-low hex glyphs {g,f,e,d,c,b,a}
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: time within the digit window, lit digit, shown value, buffer queue
  int          m_cnt;
  int          m_idx;
  logic [31:0] m_disp;
  logic [31:0] m_pend [$];
  bit          chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
      m_idx = 0;
      m_disp = 32'd0;
      m_pend.delete();
      chk_on = 1'b1;
    end else if (en) begin
      if (valid && m_pend.size() == 0) m_pend.push_back(data);
      else if (m_cnt == TD - 1 && m_idx == 7 && m_pend.size() != 0) m_disp = m_pend.pop_front();
      if (m_cnt == TD - 1) m_idx = (m_idx + 1) % 8;
      m_cnt = (m_cnt + 1) % TD;
    end else begin
      if (m_pend.size() != 0) m_disp = m_pend.pop_front();
      else if (valid) m_disp = data;
    end
  end

  always @(negedge clk) begin
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic [31:0] upper;
    if (chk_on) begin
      e_an  = (en && !rst) ? ~(8'd1 << m_idx) : 8'hFF;
      upper = m_disp >> (4 * m_idx);
      e_seg = (e_an == 8'hFF) ? 7'h7F : glyph[upper[3:0]];
`ifdef HEX_BLANK_LEADING_ZEROS_EN
      if (m_idx > 0 && upper == 32'd0) e_seg = 7'h7F;
`endif
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dp", 32'(dp), 32'd1);
      chk("ready", 32'(ready), 32'((!rst && m_pend.size() == 0) ? 1 : 0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_an(input logic [7:0] a);
    int n = 0;
    while (an !== a && n < 200) begin
      cyc(1);
      n++;
    end
    chk("wait_an", 32'(an), 32'(a));
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b1; valid = 1'b0; data = 32'd0;
    cyc(2);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_an", 32'(an), 32'hFE);
    chk("post_rst_seg", 32'(seg), 32'h40);
    cyc(40);

    // Mid-frame offer: buffered until the frame ends
    wait_an(8'hFB);
    data = 32'h1234ABCF; valid = 1'b1;
    cyc(1);
    valid = 1'b0;
    #1 chk("pend_ready_low", 32'(ready), 32'd0);
    wait_an(8'hFE);
    chk("d0_F", 32'(seg), 32'h0E);
    chk("ready_back", 32'(ready), 32'd1);
    wait_an(8'h7F);
    chk("d7_1", 32'(seg), 32'h79);

    // Offer exactly on the frame-boundary tick: display stays for one more frame
    n = 0;
    while (!(m_idx == 7 && m_cnt == TD - 1) && n < 100) begin cyc(1); n++; end
    data = 32'h55555555; valid = 1'b1;
    cyc(1);
    valid = 1'b0;
    wait_an(8'hFE);
    chk("bnd_old_F", 32'(seg), 32'h0E);
    wait_an(8'hFD);
    wait_an(8'hFE);
    chk("bnd_new_5", 32'(seg), 32'h12);

    // Second value held while buffer full
    wait_an(8'hFB);
    data = 32'h00000A00; valid = 1'b1;
    cyc(1);
    data = 32'h87654321;
    #1 chk("held_ready_low", 32'(ready), 32'd0);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin cyc(1); n++; end
    chk("held_ready_rise", 32'(ready), 32'd1);
    cyc(1);
    valid = 1'b0;
    #1 chk("held_taken", 32'(ready), 32'd0);
    wait_an(8'hFB);
    chk("d2_A", 32'(seg), 32'h08);
    wait_an(8'hF7);
`ifdef HEX_BLANK_LEADING_ZEROS_EN
    chk("d3_lz", 32'(seg), 32'h7F);
`else
    chk("d3_zero", 32'(seg), 32'h40);
`endif

    // Disabled: pending copied on entry, then direct loads
    en = 1'b0;
    cyc(1);
    chk("dis_ready", 32'(ready), 32'd1);
    chk("dis_an", 32'(an), 32'hFF);
    chk("dis_seg", 32'(seg), 32'h7F);
    data = 32'h00000008; valid = 1'b1;
    cyc(1);
    valid = 1'b0; en = 1'b1;
    wait_an(8'hFE);
    chk("en_d0_8", 32'(seg), 32'h00);

    // Reset with buffer full discards pending
    wait_an(8'hFB);
    data = 32'hDEADBEEF; valid = 1'b1;
    cyc(1);
    valid = 1'b0;
    #1 chk("rst_pend_full", 32'(ready), 32'd0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    #1;
    chk("rst2_ready", 32'(ready), 32'd1);
    chk("rst2_an", 32'(an), 32'hFE);
    chk("rst2_seg", 32'(seg), 32'h40);
    cyc(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
